// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline register with two-entry skid buffer, flush and bubble control masking
// in_ready comes straight from the skid valid register, so there is no combinational path from out_ready.

module pipe_stage_skid #(
  parameter int DATA_W      = 32,
  parameter int CTRL_W      = 16,
  parameter bit BUBBLE_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

  logic accept;
  logic emit;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & ~skid_valid_q;
  assign emit     = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      // Payloads are left in place; only the valid bits are squashed.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case ({main_valid_q, skid_valid_q})
        2'b00: begin
          if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_ctrl_d  = in_ctrl;
          end
        end
        2'b10: begin
          if (accept && emit) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
          end else if (emit) begin
            main_valid_d = 1'b0;
          end
        end
        2'b11: begin
          if (emit) begin
            skid_valid_d = 1'b0;
            main_data_d  = skid_data_q;
            main_ctrl_d  = skid_ctrl_q;
          end
        end
        default: begin
          // Unreachable skid-only encoding: fall back to empty.
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = (BUBBLE_ZERO && !main_valid_q) ? '0 : main_ctrl_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - vector table plus queue-model random check for pipe_stage_skid
// Instance a: defaults (32/16, masked bubbles); instance b: 64/8 with stale bubble control.

module tb_pipe_stage_skid;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [15:0] a_in_ctrl, a_out_ctrl;
  logic [1:0]  a_occ;

  logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_in_data, b_out_data;
  logic [7:0]  b_in_ctrl, b_out_ctrl;
  logic [1:0]  b_occ;

  pipe_stage_skid u_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .occupancy(a_occ)
  );

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .BUBBLE_ZERO(1'b0)) u_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .occupancy(b_occ)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        rst, flush, iv;
    logic [31:0] d;
    logic [15:0] c;
    logic        ordy;
    logic        ev;
    logic [31:0] ed;
    logic        chk_d;
    logic [15:0] ec;
    logic [1:0]  eocc;
    logic        erdy;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] cf(input logic [31:0] d);
    return d[15:0] ^ 16'hC3C3;
  endfunction

  task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] d,
                     input logic [15:0] c, input logic o, input logic ev, input logic [31:0] ed,
                     input logic cd, input logic [15:0] ec, input logic [1:0] occ, input logic rdy);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.c = c; v.ordy = o;
    v.ev = ev; v.ed = ed; v.chk_d = cd; v.ec = ec; v.eocc = occ; v.erdy = rdy;
    tbl.push_back(v);
  endtask

  // Emits a row for an accepted word whose result is a valid main entry.
  task automatic add_v(input logic iv, input logic [31:0] d, input logic o,
                       input logic [31:0] ed, input logic [1:0] occ);
    add(1'b0, 1'b0, iv, d, cf(d), o, 1'b1, ed, 1'b1, cf(ed), occ, occ != 2'd2);
  endtask

  task automatic add_empty(input logic r, input logic f, input logic iv, input logic [31:0] d,
                           input logic [15:0] c, input logic o, input logic cd);
    add(r, f, iv, d, c, o, 1'b0, 32'h0, cd, 16'h0, 2'd0, 1'b1);
  endtask

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
  } ent_t;

  ent_t mq[$];

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_in_ctrl = '0; a_out_ready = 1'b0;
    b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_ctrl = '0; b_out_ready = 1'b0;

    // Reset, then a full-rate stream.
    add_empty(1'b1, 1'b0, 1'b1, 32'h99, cf(32'h99), 1'b1, 1'b1);
    for (int i = 1; i <= 8; i++) add_v(1'b1, i, 1'b1, i, 2'd1);
    add_empty(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    // Stall with skid fill, then back-to-back drain.
    add_v(1'b1, 32'hA, 1'b1, 32'hA, 2'd1);
    add_v(1'b1, 32'hB, 1'b1, 32'hB, 2'd1);
    add_v(1'b1, 32'hC, 1'b0, 32'hB, 2'd2);
    add_v(1'b1, 32'hDD, 1'b0, 32'hB, 2'd2);
    add_v(1'b0, 32'h0, 1'b0, 32'hB, 2'd2);
    add_v(1'b0, 32'h0, 1'b0, 32'hB, 2'd2);
    add_v(1'b0, 32'h0, 1'b1, 32'hC, 2'd1);
    add_empty(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    // Flush while full, with a new word offered in the flush cycle.
    add_v(1'b1, 32'h11, 1'b0, 32'h11, 2'd1);
    add_v(1'b1, 32'h22, 1'b0, 32'h11, 2'd2);
    add_empty(1'b0, 1'b1, 1'b1, 32'hD0, cf(32'hD0), 1'b0, 1'b0);
    add_empty(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    add_empty(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    // Bubbles with all-ones control on the input.
    for (int i = 0; i < 5; i++) add_empty(1'b0, 1'b0, 1'b0, 32'h0, 16'hFFFF, 1'b1, 1'b0);
    // Reset during a full stall, then a fresh word.
    add_v(1'b1, 32'h33, 1'b0, 32'h33, 2'd1);
    add_v(1'b1, 32'h44, 1'b0, 32'h33, 2'd2);
    add_empty(1'b1, 1'b0, 1'b1, 32'h55, cf(32'h55), 1'b0, 1'b1);
    add_v(1'b1, 32'hE0, 1'b0, 32'hE0, 2'd1);
    add_empty(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    // Reset beats flush; flush beats emit and accept in HALF.
    add_v(1'b1, 32'h66, 1'b0, 32'h66, 2'd1);
    add_empty(1'b1, 1'b1, 1'b1, 32'h67, cf(32'h67), 1'b0, 1'b1);
    add_v(1'b1, 32'h77, 1'b0, 32'h77, 2'd1);
    add_empty(1'b0, 1'b1, 1'b1, 32'h78, cf(32'h78), 1'b1, 1'b0);
    add_empty(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 1'b0);

    foreach (tbl[i]) begin
      @(negedge clk);
      a_rst = tbl[i].rst; a_flush = tbl[i].flush; a_in_valid = tbl[i].iv;
      a_in_data = tbl[i].d; a_in_ctrl = tbl[i].c; a_out_ready = tbl[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("row%0d out_valid", i), {63'b0, a_out_valid}, {63'b0, tbl[i].ev});
      check($sformatf("row%0d out_ctrl", i), {48'b0, a_out_ctrl}, {48'b0, tbl[i].ec});
      check($sformatf("row%0d occupancy", i), {62'b0, a_occ}, {62'b0, tbl[i].eocc});
      check($sformatf("row%0d in_ready", i), {63'b0, a_in_ready}, {63'b0, tbl[i].erdy});
      if (tbl[i].chk_d) check($sformatf("row%0d out_data", i), {32'b0, a_out_data}, {32'b0, tbl[i].ed});
    end
    @(negedge clk);
    a_in_valid = 1'b0; a_flush = 1'b0; a_rst = 1'b0;

    // Instance b: stale control survives a flush and bubbles.
    @(negedge clk);
    b_rst = 1'b0; b_in_valid = 1'b1; b_in_data = 64'h1234; b_in_ctrl = 8'h5A; b_out_ready = 1'b0;
    @(posedge clk); #1;
    check("b accept valid", {63'b0, b_out_valid}, 64'd1);
    check("b accept ctrl", {56'b0, b_out_ctrl}, 64'h5A);
    @(negedge clk);
    b_flush = 1'b1; b_in_data = 64'h9999; b_in_ctrl = 8'h11;
    @(posedge clk); #1;
    check("b flush valid", {63'b0, b_out_valid}, 64'd0);
    check("b flush ctrl", {56'b0, b_out_ctrl}, 64'h5A);
    check("b flush ready", {63'b0, b_in_ready}, 64'd1);
    @(negedge clk);
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_ctrl = 8'hFF; b_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("b bubble%0d ctrl", i), {56'b0, b_out_ctrl}, 64'h5A);
    end

    // Random traffic on b against a FIFO model of at most two entries.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic ordy, iv, fl, rd0, rd1;
      @(negedge clk);
      check("rnd out_valid", {63'b0, b_out_valid}, {63'b0, mq.size() > 0});
      check("rnd occupancy", {62'b0, b_occ}, 64'(mq.size()));
      check("rnd in_ready", {63'b0, b_in_ready}, {63'b0, mq.size() < 2});
      if (mq.size() > 0) begin
        check("rnd out_data", b_out_data, mq[0].d);
        check("rnd out_ctrl", {56'b0, b_out_ctrl}, {56'b0, mq[0].c});
      end
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 4) < 3);
      fl   = ($urandom_range(0, 49) == 0);
      b_in_valid = iv; b_flush = fl;
      b_in_data  = {$urandom, $urandom};
      b_in_ctrl  = 8'($urandom);
      b_out_ready = ~ordy;
      #1 rd0 = b_in_ready;
      b_out_ready = ordy;
      #1 rd1 = b_in_ready;
      check("rnd in_ready vs out_ready", {63'b0, rd1}, {63'b0, rd0});
      @(posedge clk);
      if (fl) mq.delete();
      else begin
        logic acc, em;
        acc = iv && (mq.size() < 2);
        em  = (mq.size() > 0) && ordy;
        if (em) void'(mq.pop_front());
        if (acc) mq.push_back('{d: b_in_data, c: b_in_ctrl});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
